// File: rtl/irom_pkg.sv
// Shared definitions for the instruction-fetch front end.
// Holds the instruction width, FSM state encodings and the bus-beat helper.
// No ports; imported by irom_fetch and irom_beat_ctrl.
package irom_pkg;

  localparam int INST_W = 32;

  // Fetch FSM state encoding
  typedef logic [1:0] fetch_state_t;
  localparam fetch_state_t IDLE   = 2'd0;
  localparam fetch_state_t ACCESS = 2'd1;
  localparam fetch_state_t DONE   = 2'd2;

  // Number of external bus beats needed to assemble one instruction
  function automatic int beats_of(input int data_w);
    return INST_W / data_w;
  endfunction

endpackage

// File: rtl/irom_beat_ctrl.sv
// Beat/wait-state sequencer for the external instruction memory.
// Ports: clk/rst, start/active/flush control from the FSM, req_addr (word address),
//        beat index and beat_sample/last_beat pulses back to the FSM, mem_* bus drive.
module irom_beat_ctrl
  import irom_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 20,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              active,
  input  logic              flush,
  input  logic [29:0]       req_addr,
  output logic [0:0]        beat,
  output logic              beat_sample,
  output logic              last_beat,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_ce_n,
  output logic              mem_oe_n
);

  localparam int           BEATS     = beats_of(DATA_W);
  localparam logic [3:0]   WAIT_LAST = 4'(WAIT_CYCLES - 1);
  localparam logic [0:0]   BEAT_LAST = 1'(BEATS - 1);

  logic [3:0]  wait_cnt;
  logic [31:0] lin_addr;
  logic        unused_hi;

  // Data is sampled on the last wait cycle of each beat
  assign beat_sample = active && (wait_cnt == WAIT_LAST);
  assign last_beat   = beat_sample && (beat == BEAT_LAST);

  always_ff @(posedge clk) begin
    if (rst || flush || start) begin
      wait_cnt <= '0;
      beat     <= '0;
    end else if (active) begin
      if (beat_sample) begin
        wait_cnt <= '0;
        beat     <= last_beat ? 1'b0 : beat + 1'b1;
      end else begin
        wait_cnt <= wait_cnt + 4'd1;
      end
    end
  end

  // Bus-word address; bits above ADDR_W wrap silently
  assign lin_addr  = ({2'b00, req_addr} * 32'(BEATS)) + {31'd0, beat};
  assign unused_hi = ^lin_addr;

  // ce/oe stay low across all beats of one access
  assign mem_addr  = active ? lin_addr[ADDR_W-1:0] : '0;
  assign mem_ce_n  = ~active;
  assign mem_oe_n  = ~active;

endmodule

// File: rtl/irom_fetch.sv
// IF-stage instruction fetch: fetches a 32-bit word over a 16/32-bit async bus and holds it.
// Ports: clk/rst, fetch_ce/fetch_addr/flush from PC logic, inst/inst_valid/fetch_stall to
//        the pipeline, mem_addr/mem_ce_n/mem_oe_n/mem_we_n/mem_rdata to external memory.
module irom_fetch
  import irom_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 20,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_ce,
  input  logic [31:0]       fetch_addr,
  input  logic              flush,
  output logic [31:0]       inst,
  output logic              inst_valid,
  output logic              fetch_stall,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_ce_n,
  output logic              mem_oe_n,
  output logic              mem_we_n,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int BEATS = beats_of(DATA_W);

  fetch_state_t      state;
  logic [29:0]       req_addr;
  logic [29:0]       held_addr;
  logic [INST_W-1:0] held_inst;
  logic              held_valid;
  logic [INST_W-1:0] asm_word;

  logic              hit;
  logic              miss;
  logic              start;
  logic [0:0]        beat;
  logic              beat_sample;
  logic              last_beat;
  logic              unused_lsb;

  assign unused_lsb = ^fetch_addr[1:0];

  assign hit   = fetch_ce && held_valid && (fetch_addr[31:2] == held_addr);
  assign miss  = fetch_ce && !hit;
  assign start = (state == IDLE) && miss && !flush;

  assign inst        = hit ? held_inst : '0;
  assign inst_valid  = hit;
  // Flush releases the pipeline in its own cycle so the redirect PC can load
  assign fetch_stall = miss && !flush;
  assign mem_we_n    = 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      req_addr   <= '0;
      held_addr  <= '0;
      held_inst  <= '0;
      held_valid <= 1'b0;
      asm_word   <= '0;
    end else if (flush) begin
      // Flush beats a coincident DONE: the just-assembled word is dropped
      state      <= IDLE;
      held_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            req_addr <= fetch_addr[31:2];
            state    <= ACCESS;
          end
        end
        ACCESS: begin
          if (beat_sample) begin
            // Little-endian assembly: beat 0 lands in the low bits
            for (int b = 0; b < BEATS; b++) begin
              if (beat == 1'(b)) begin
                asm_word[b*DATA_W +: DATA_W] <= mem_rdata;
              end
            end
            if (last_beat) begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          held_inst  <= asm_word;
          held_addr  <= req_addr;
          held_valid <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  irom_beat_ctrl #(
    .DATA_W      (DATA_W),
    .ADDR_W      (ADDR_W),
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_beat_ctrl (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .active      (state == ACCESS),
    .flush       (flush),
    .req_addr    (req_addr),
    .beat        (beat),
    .beat_sample (beat_sample),
    .last_beat   (last_beat),
    .mem_addr    (mem_addr),
    .mem_ce_n    (mem_ce_n),
    .mem_oe_n    (mem_oe_n)
  );

endmodule

// File: tb/tb_irom_fetch.sv
// Bench for irom_fetch: a 16-bit/2-wait instance driven from a vector table and a
// 32-bit/3-wait instance driven by short hand-written sequences.
module tb_irom_fetch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- 16-bit bus, 2 wait states ----------------
  logic        rst;
  logic        fetch_ce;
  logic [31:0] fetch_addr;
  logic        flush;
  logic [31:0] inst;
  logic        inst_valid;
  logic        fetch_stall;
  logic [19:0] mem_addr;
  logic        mem_ce_n;
  logic        mem_oe_n;
  logic        mem_we_n;
  logic [15:0] mem_rdata;

  irom_fetch #(.DATA_W(16), .ADDR_W(20), .WAIT_CYCLES(2)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_ce    (fetch_ce),
    .fetch_addr  (fetch_addr),
    .flush       (flush),
    .inst        (inst),
    .inst_valid  (inst_valid),
    .fetch_stall (fetch_stall),
    .mem_addr    (mem_addr),
    .mem_ce_n    (mem_ce_n),
    .mem_oe_n    (mem_oe_n),
    .mem_we_n    (mem_we_n),
    .mem_rdata   (mem_rdata)
  );

  // ---------------- 32-bit bus, 3 wait states ----------------
  logic        rst32;
  logic        fetch_ce32;
  logic [31:0] fetch_addr32;
  logic        flush32;
  logic [31:0] inst32;
  logic        inst_valid32;
  logic        fetch_stall32;
  logic [19:0] mem_addr32;
  logic        mem_ce_n32;
  logic        mem_oe_n32;
  logic        mem_we_n32;
  logic [31:0] mem_rdata32;

  irom_fetch #(.DATA_W(32), .ADDR_W(20), .WAIT_CYCLES(3)) u_dut32 (
    .clk         (clk),
    .rst         (rst32),
    .fetch_ce    (fetch_ce32),
    .fetch_addr  (fetch_addr32),
    .flush       (flush32),
    .inst        (inst32),
    .inst_valid  (inst_valid32),
    .fetch_stall (fetch_stall32),
    .mem_addr    (mem_addr32),
    .mem_ce_n    (mem_ce_n32),
    .mem_oe_n    (mem_oe_n32),
    .mem_we_n    (mem_we_n32),
    .mem_rdata   (mem_rdata32)
  );

  // Memory models: read data is only valid once the address has been held
  // with ce low for at least one full cycle; otherwise a garbage pattern.
  logic [19:0] prev_addr;
  logic        prev_act;
  logic [19:0] prev_addr32;
  logic        prev_act32;

  always @(posedge clk) begin
    prev_addr   <= mem_addr;
    prev_act    <= !mem_ce_n;
    prev_addr32 <= mem_addr32;
    prev_act32  <= !mem_ce_n32;
  end

  function automatic logic [15:0] mem16(input logic [19:0] a);
    case (a)
      20'h00008: return 16'h5678;
      20'h00009: return 16'h1234;
      20'h0000A: return 16'hBEEF;
      20'h0000B: return 16'hCAFE;
      default:   return 16'h0BAD;
    endcase
  endfunction

  assign mem_rdata = (!mem_ce_n && prev_act && prev_addr == mem_addr) ? mem16(mem_addr) : 16'hDEAD;
  assign mem_rdata32 = (!mem_ce_n32 && prev_act32 && prev_addr32 == mem_addr32) ?
                       ((mem_addr32 == 20'h00041) ? 32'h2408_0001 : 32'h0BAD_0BAD) : 32'hDEAD_BEEF;

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        ce;
    logic [31:0] addr;
    logic        fl;
    logic [31:0] e_inst;
    logic        e_vld;
    logic        e_stall;
    logic        e_ce_n;
    logic [19:0] e_maddr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic ce, input logic [31:0] addr, input logic fl,
                             input logic [31:0] e_inst, input logic e_vld, input logic e_stall,
                             input logic e_ce_n, input logic [19:0] e_maddr);
    vec_t r;
    r.ce = ce; r.addr = addr; r.fl = fl; r.e_inst = e_inst; r.e_vld = e_vld;
    r.e_stall = e_stall; r.e_ce_n = e_ce_n; r.e_maddr = e_maddr;
    return r;
  endfunction

  // One 32-bit-bus fetch from IDLE: ACCESS cycles 1..3, DONE 4, valid at 5
  task automatic run_fetch32(input logic [31:0] addr, input logic [19:0] e_maddr,
                             input logic [31:0] e_inst);
    fetch_ce32   = 1'b1;
    fetch_addr32 = addr;
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      chk($sformatf("w32 stall c%0d", c), {31'd0, fetch_stall32}, {31'd0, (c < 5)});
      chk($sformatf("w32 ce_n c%0d", c), {31'd0, mem_ce_n32}, {31'd0, !(c >= 1 && c <= 3)});
      chk($sformatf("w32 vld c%0d", c), {31'd0, inst_valid32}, {31'd0, (c == 5)});
      chk($sformatf("w32 inst c%0d", c), inst32, (c == 5) ? e_inst : 32'h0);
      if (c >= 1 && c <= 3) chk($sformatf("w32 maddr c%0d", c), {12'd0, mem_addr32}, {12'd0, e_maddr});
      @(posedge clk); #1;
    end
  endtask

  localparam logic [31:0] W10 = 32'h1234_5678;
  localparam logic [31:0] W14 = 32'hCAFE_BEEF;

  initial begin
    rst = 1'b1; fetch_ce = 1'b0; fetch_addr = '0; flush = 1'b0;
    rst32 = 1'b1; fetch_ce32 = 1'b0; fetch_addr32 = '0; flush32 = 1'b0;

    //              ce  addr         fl  inst   vld  stl  ce_n maddr
    tbl.push_back(v(1, 32'h10, 0, 0,   0, 1, 1, 0));      // 0: miss seen in IDLE
    tbl.push_back(v(1, 32'h10, 0, 0,   0, 1, 0, 20'h8));
    tbl.push_back(v(1, 32'h10, 0, 0,   0, 1, 0, 20'h8));
    tbl.push_back(v(1, 32'h10, 0, 0,   0, 1, 0, 20'h9));
    tbl.push_back(v(1, 32'h10, 0, 0,   0, 1, 0, 20'h9));
    tbl.push_back(v(1, 32'h10, 0, 0,   0, 1, 1, 0));      // 5: DONE
    tbl.push_back(v(1, 32'h10, 0, W10, 1, 0, 1, 0));      // 6: valid
    tbl.push_back(v(1, 32'h10, 0, W10, 1, 0, 1, 0));
    tbl.push_back(v(1, 32'h10, 0, W10, 1, 0, 1, 0));
    tbl.push_back(v(0, 32'h10, 0, 0,   0, 0, 1, 0));      // 9: fetch_ce low
    tbl.push_back(v(1, 32'h10, 0, W10, 1, 0, 1, 0));      // 10: re-raise hits
    tbl.push_back(v(1, 32'h13, 0, W10, 1, 0, 1, 0));      // 11: low bits ignored
    tbl.push_back(v(0, 32'h10, 1, 0,   0, 0, 1, 0));      // 12: flush invalidates
    tbl.push_back(v(1, 32'h10, 0, 0,   0, 1, 1, 0));      // 13: now a miss
    tbl.push_back(v(1, 32'h10, 0, 0,   0, 1, 0, 20'h8));
    tbl.push_back(v(1, 32'h10, 0, 0,   0, 1, 0, 20'h8));
    tbl.push_back(v(1, 32'h10, 1, 0,   0, 0, 0, 20'h9));  // 16: flush in beat 1
    tbl.push_back(v(1, 32'h10, 0, 0,   0, 1, 1, 0));      // 17: bus released
    tbl.push_back(v(1, 32'h10, 0, 0,   0, 1, 0, 20'h8));  // 18: restart at beat 0
    tbl.push_back(v(1, 32'h10, 0, 0,   0, 1, 0, 20'h8));
    tbl.push_back(v(1, 32'h10, 0, 0,   0, 1, 0, 20'h9));
    tbl.push_back(v(1, 32'h10, 0, 0,   0, 1, 0, 20'h9));
    tbl.push_back(v(1, 32'h10, 0, 0,   0, 1, 1, 0));
    tbl.push_back(v(1, 32'h10, 0, W10, 1, 0, 1, 0));      // 23
    tbl.push_back(v(0, 32'h10, 1, 0,   0, 0, 1, 0));      // 24: flush
    tbl.push_back(v(1, 32'h10, 0, 0,   0, 1, 1, 0));
    tbl.push_back(v(1, 32'h10, 0, 0,   0, 1, 0, 20'h8));
    tbl.push_back(v(1, 32'h14, 0, 0,   0, 1, 0, 20'h8));  // 27: addr changes mid-fetch
    tbl.push_back(v(1, 32'h14, 0, 0,   0, 1, 0, 20'h9));
    tbl.push_back(v(1, 32'h14, 0, 0,   0, 1, 0, 20'h9));
    tbl.push_back(v(1, 32'h14, 0, 0,   0, 1, 1, 0));      // 30: DONE for 0x10
    tbl.push_back(v(1, 32'h14, 0, 0,   0, 1, 1, 0));      // 31: 0x14 misses
    tbl.push_back(v(1, 32'h14, 0, 0,   0, 1, 0, 20'hA));
    tbl.push_back(v(1, 32'h14, 0, 0,   0, 1, 0, 20'hA));
    tbl.push_back(v(1, 32'h14, 0, 0,   0, 1, 0, 20'hB));
    tbl.push_back(v(1, 32'h14, 0, 0,   0, 1, 0, 20'hB));
    tbl.push_back(v(1, 32'h14, 0, 0,   0, 1, 1, 0));
    tbl.push_back(v(1, 32'h14, 0, W14, 1, 0, 1, 0));      // 37
    tbl.push_back(v(1, 32'h10, 0, 0,   0, 1, 1, 0));      // 38: 0x10 no longer held
    tbl.push_back(v(1, 32'h10, 0, 0,   0, 1, 0, 20'h8));
    tbl.push_back(v(1, 32'h10, 0, 0,   0, 1, 0, 20'h8));
    tbl.push_back(v(1, 32'h10, 0, 0,   0, 1, 0, 20'h9));
    tbl.push_back(v(1, 32'h10, 0, 0,   0, 1, 0, 20'h9));
    tbl.push_back(v(1, 32'h10, 1, 0,   0, 0, 1, 0));      // 43: flush in DONE
    tbl.push_back(v(1, 32'h10, 0, 0,   0, 1, 1, 0));      // 44: word discarded
    tbl.push_back(v(0, 32'h10, 1, 0,   0, 0, 0, 20'h8));
    tbl.push_back(v(0, 32'h10, 0, 0,   0, 0, 1, 0));

    // Reset state on both instances
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst inst", inst, 32'h0);
    chk("rst vld", {31'd0, inst_valid}, 32'h0);
    chk("rst stall", {31'd0, fetch_stall}, 32'h0);
    chk("rst ce_n", {31'd0, mem_ce_n}, 32'h1);
    chk("rst oe_n", {31'd0, mem_oe_n}, 32'h1);
    chk("rst we_n", {31'd0, mem_we_n}, 32'h1);
    chk("rst maddr", {12'd0, mem_addr}, 32'h0);
    chk("rst32 ce_n", {31'd0, mem_ce_n32}, 32'h1);
    chk("rst32 maddr", {12'd0, mem_addr32}, 32'h0);
    chk("rst32 vld", {31'd0, inst_valid32}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    rst32 = 1'b0;

    // Table-driven run on the 16-bit instance
    for (int i = 0; i < tbl.size(); i++) begin
      fetch_ce   = tbl[i].ce;
      fetch_addr = tbl[i].addr;
      flush      = tbl[i].fl;
      @(negedge clk);
      chk($sformatf("v%0d inst", i), inst, tbl[i].e_inst);
      chk($sformatf("v%0d vld", i), {31'd0, inst_valid}, {31'd0, tbl[i].e_vld});
      chk($sformatf("v%0d stall", i), {31'd0, fetch_stall}, {31'd0, tbl[i].e_stall});
      chk($sformatf("v%0d ce_n", i), {31'd0, mem_ce_n}, {31'd0, tbl[i].e_ce_n});
      chk($sformatf("v%0d oe_n", i), {31'd0, mem_oe_n}, {31'd0, tbl[i].e_ce_n});
      if (!tbl[i].e_ce_n) chk($sformatf("v%0d maddr", i), {12'd0, mem_addr}, {12'd0, tbl[i].e_maddr});
      @(posedge clk); #1;
    end
    flush = 1'b0;

    // 32-bit bus: single-beat fetch, then an address that aliases after wrap
    run_fetch32(32'h0000_0104, 20'h00041, 32'h2408_0001);
    @(negedge clk);
    chk("w32 hold hit", {31'd0, inst_valid32}, 32'h1);
    chk("w32 hold ce_n", {31'd0, mem_ce_n32}, 32'h1);
    @(posedge clk); #1;
    run_fetch32(32'h0040_0104, 20'h00041, 32'h2408_0001);

    // Reset in the middle of an access
    fetch_addr32 = 32'h0000_0200;
    @(posedge clk); #1;                 // IDLE -> ACCESS
    @(negedge clk);
    chk("w32 pre-rst ce_n", {31'd0, mem_ce_n32}, 32'h0);
    @(posedge clk); #1;
    rst32 = 1'b1;
    fetch_ce32 = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("w32 rst ce_n", {31'd0, mem_ce_n32}, 32'h1);
    chk("w32 rst vld", {31'd0, inst_valid32}, 32'h0);
    @(posedge clk); #1;
    rst32 = 1'b0;
    fetch_ce32 = 1'b1;
    fetch_addr32 = 32'h0040_0104;       // previously held, now cleared by reset
    @(negedge clk);
    chk("w32 post-rst miss", {31'd0, fetch_stall32}, 32'h1);
    chk("w32 post-rst vld", {31'd0, inst_valid32}, 32'h0);
    @(posedge clk); #1;
    fetch_ce32 = 1'b0;
    repeat (8) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
